immed_gen_pipe: RTL and testbench

- Parametrised, registered immediate generator for the decode stage; successor to the combinational ImmedGen.
- Supports XLEN 32 or 64, adds CSR zimm and shift-amount formats, and flags illegal selects instead of emitting a junk constant.
- Sits between the IF/ID register and the ID/EX register, with valid/ready handshakes on both sides.
- Contains a 2-entry skid buffer, so back-pressure never drops or reorders an instruction; carries a sideband tag (e.g. PC) alongside each result.

---
 rtl/immed_gen_pipe_if.sv | 28 ++
 rtl/immed_gen_pipe.sv | 102 ++++++++++
 tb/tb_immed_gen_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/immed_gen_pipe_if.sv
// Decode-stage immediate generator bus: upstream instruction handshake,
// downstream result handshake and the flush strobe.
interface immed_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      ir;
    logic [2:0]       immed_sel;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immed_ext;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport master (
        output in_valid, ir, immed_sel, in_tag, flush, out_ready,
        input  in_ready, out_valid, immed_ext, out_tag, illegal
    );

    modport slave (
        input  in_valid, ir, immed_sel, in_tag, flush, out_ready,
        output in_ready, out_valid, immed_ext, out_tag, illegal
    );
endinterface

// File: rtl/immed_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (main M, skid K)
// carrying {immed, tag, illegal} in FIFO order.
module immed_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    immed_gen_pipe_if.slave   bus
);
    logic [31:7]        instr;
    logic signed [31:0] s32;
    logic [5:0]         z6;
    logic               use_z;
    logic               nxt_ill;
    logic [XLEN-1:0]    nxt_imm;

    logic               m_valid;
    logic [XLEN-1:0]    m_imm;
    logic [TAG_W-1:0]   m_tag;
    logic               m_ill;
    logic               k_free;
    logic [XLEN-1:0]    k_imm;
    logic [TAG_W-1:0]   k_tag;
    logic               k_ill;

    logic               accept;
    logic               m_free;

    assign instr = bus.ir;

    // Sign-extended formats are built at 32 bits and widened by the cast.
    always_comb begin
        s32     = '0;
        z6      = '0;
        use_z   = 1'b0;
        nxt_ill = 1'b0;
        case (bus.immed_sel)
            3'b000: s32 = {{20{instr[31]}}, instr[31:20]};
            3'b001: s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: s32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: s32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100: s32 = {instr[31:12], 12'b0};
            3'b101: begin
                use_z = 1'b1;
                z6    = {1'b0, instr[19:15]};
            end
            3'b110: begin
                use_z = 1'b1;
                z6    = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
            end
            default: nxt_ill = 1'b1;
        endcase
        nxt_imm = use_z ? XLEN'(z6) : XLEN'(s32);
    end

    assign accept = bus.in_valid && k_free;
    assign m_free = !m_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_imm   <= '0;
            m_tag   <= '0;
            m_ill   <= 1'b0;
            k_free  <= 1'b1;
            k_imm   <= '0;
            k_tag   <= '0;
            k_ill   <= 1'b0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
            k_free  <= 1'b1;
        end else if (m_free) begin
            // A full skid blocks acceptance, so K draining and a new input never coincide.
            if (!k_free) begin
                m_valid <= 1'b1;
                m_imm   <= k_imm;
                m_tag   <= k_tag;
                m_ill   <= k_ill;
                k_free  <= 1'b1;
            end else if (accept) begin
                m_valid <= 1'b1;
                m_imm   <= nxt_imm;
                m_tag   <= bus.in_tag;
                m_ill   <= nxt_ill;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            k_free <= 1'b0;
            k_imm  <= nxt_imm;
            k_tag  <= bus.in_tag;
            k_ill  <= nxt_ill;
        end
    end

    assign bus.in_ready  = k_free;
    assign bus.out_valid = m_valid;
    assign bus.immed_ext = m_imm;
    assign bus.out_tag   = m_tag;
    assign bus.illegal   = m_ill;
endmodule

// File: tb/tb_immed_gen_pipe.sv
// Directed bench: XLEN=32 and XLEN=64 instances driven in lockstep, format table
// plus stall, flush and asynchronous-reset sequences.
module tb_immed_gen_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    immed_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    immed_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    immed_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    immed_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] tag;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
    } vec_t;

    vec_t vecs[13];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] sel,
                         input logic [31:0] tag);
        b32.in_valid = v;  b32.ir = instr[31:7];  b32.immed_sel = sel;  b32.in_tag = tag;
        b64.in_valid = v;  b64.ir = instr[31:7];  b64.immed_sel = sel;  b64.in_tag = tag;
    endtask

    task automatic set_ctl(input logic ordy, input logic fl);
        b32.out_ready = ordy;  b32.flush = fl;
        b64.out_ready = ordy;  b64.flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic v, input logic [31:0] e32,
                           input logic [63:0] e64, input logic [31:0] tag, input logic ill);
        chk({name, ".v32"},   64'(b32.out_valid), 64'(v));
        chk({name, ".v64"},   64'(b64.out_valid), 64'(v));
        chk({name, ".imm32"}, 64'(b32.immed_ext), 64'(e32));
        chk({name, ".imm64"}, b64.immed_ext,      e64);
        chk({name, ".tag32"}, 64'(b32.out_tag),   64'(tag));
        chk({name, ".tag64"}, 64'(b64.out_tag),   64'(tag));
        chk({name, ".ill32"}, 64'(b32.illegal),   64'(ill));
        chk({name, ".ill64"}, 64'(b64.illegal),   64'(ill));
    endtask

    task automatic chk_valid(input string name, input logic v);
        chk({name, ".v32"}, 64'(b32.out_valid), 64'(v));
        chk({name, ".v64"}, 64'(b64.out_valid), 64'(v));
    endtask

    task automatic chk_ready(input string name, input logic r);
        chk({name, ".rdy32"}, 64'(b32.in_ready), 64'(r));
        chk({name, ".rdy64"}, 64'(b64.in_ready), 64'(r));
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'd0, 32'h100, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h7FF00093, 3'd0, 32'h101, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[2]  = '{32'hFE000C23, 3'd1, 32'h102, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        vecs[3]  = '{32'h7E000FA3, 3'd1, 32'h103, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[4]  = '{32'hFE000EE3, 3'd2, 32'h104, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[5]  = '{32'h00000AE3, 3'd2, 32'h105, 32'h00000814, 64'h0000000000000814, 1'b0};
        vecs[6]  = '{32'hFFFFF06F, 3'd3, 32'h106, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0};
        vecs[7]  = '{32'h001AB06F, 3'd3, 32'h107, 32'h000AB800, 64'h00000000000AB800, 1'b0};
        vecs[8]  = '{32'h123450B7, 3'd4, 32'h108, 32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[9]  = '{32'h800000B7, 3'd4, 32'h109, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[10] = '{32'h800B0073, 3'd5, 32'h10A, 32'h00000016, 64'h0000000000000016, 1'b0};
        vecs[11] = '{32'h83F01013, 3'd6, 32'h10B, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[12] = '{32'hFFFFFFFF, 3'd7, 32'h10C, 32'h00000000, 64'h0000000000000000, 1'b1};

        set_ctl(1'b1, 1'b0);
        drive(1'b1, 32'hFFFFFFFF, 3'd0, 32'hDEAD);
        #1 rst_n = 1'b0;
        #10;
        chk_all("reset", 1'b0, '0, '0, '0, 1'b0);
        chk_ready("reset", 1'b1);
        @(negedge clk) rst_n = 1'b1;
        drive(1'b0, '0, 3'd0, '0);

        // Back-to-back format table: each result appears one edge after its input.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].sel, vecs[i].tag);
            step();
            chk_all($sformatf("vec%0d", i), 1'b1, vecs[i].e32, vecs[i].e64, vecs[i].tag, vecs[i].ill);
        end
        drive(1'b0, '0, 3'd0, '0);
        step();
        chk_valid("drain", 1'b0);

        // Stall: A in M, B in K, C held upstream, then drain in order.
        set_ctl(1'b0, 1'b0);
        drive(1'b1, 32'h7FF00093, 3'd0, 32'hA);
        step();
        chk_all("stallA0", 1'b1, 32'h7FF, 64'h7FF, 32'hA, 1'b0);
        chk_ready("stallA0", 1'b1);
        drive(1'b1, 32'h123450B7, 3'd4, 32'hB);
        step();
        chk_all("stallA1", 1'b1, 32'h7FF, 64'h7FF, 32'hA, 1'b0);
        chk_ready("stallA1", 1'b0);
        drive(1'b1, 32'h800B0073, 3'd5, 32'hC);
        step();
        chk_all("stallA2", 1'b1, 32'h7FF, 64'h7FF, 32'hA, 1'b0);
        chk_ready("stallA2", 1'b0);
        set_ctl(1'b1, 1'b0);
        step();
        chk_all("stallB", 1'b1, 32'h12345000, 64'h12345000, 32'hB, 1'b0);
        chk_ready("stallB", 1'b1);
        step();
        chk_all("stallC", 1'b1, 32'h16, 64'h16, 32'hC, 1'b0);
        drive(1'b0, '0, 3'd0, '0);
        step();
        chk_valid("stallEnd", 1'b0);

        // Flush with M and K full and a new input presented.
        set_ctl(1'b0, 1'b0);
        drive(1'b1, 32'hFFF00093, 3'd0, 32'hD);
        step();
        drive(1'b1, 32'hFE000EE3, 3'd2, 32'hE);
        step();
        chk_ready("flushFull", 1'b0);
        drive(1'b1, 32'h800000B7, 3'd4, 32'hF);
        set_ctl(1'b0, 1'b1);
        step();
        set_ctl(1'b1, 1'b0);
        chk_valid("flush1", 1'b0);
        chk_ready("flush1", 1'b1);
        drive(1'b1, 32'hFE000C23, 3'd1, 32'h6);
        step();
        chk_all("postFlush", 1'b1, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 32'h6, 1'b0);
        drive(1'b0, '0, 3'd0, '0);
        step();
        chk_valid("postFlushEnd", 1'b0);

        // Flush while M is full and an acceptable input is presented.
        set_ctl(1'b1, 1'b0);
        drive(1'b1, 32'h7FF00093, 3'd0, 32'h11);
        step();
        drive(1'b1, 32'h83F01013, 3'd6, 32'h12);
        set_ctl(1'b0, 1'b1);
        step();
        set_ctl(1'b1, 1'b0);
        drive(1'b0, '0, 3'd0, '0);
        chk_valid("flush2", 1'b0);
        step();
        chk_valid("flush2b", 1'b0);

        // Asynchronous reset between edges while stalled with both entries full.
        set_ctl(1'b0, 1'b0);
        drive(1'b1, 32'hFFFFF06F, 3'd3, 32'h21);
        step();
        drive(1'b1, 32'h001AB06F, 3'd3, 32'h22);
        step();
        chk_ready("preRst", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("asyncRst", 1'b0, '0, '0, '0, 1'b0);
        chk_ready("asyncRst", 1'b1);
        drive(1'b1, 32'hFFFFFFFF, 3'd7, 32'h23);
        step();
        chk_all("rstHeld", 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        set_ctl(1'b1, 1'b0);
        drive(1'b1, 32'h00000AE3, 3'd2, 32'h24);
        step();
        chk_all("postRst", 1'b1, 32'h814, 64'h814, 32'h24, 1'b0);
        drive(1'b0, '0, 3'd0, '0);
        step();
        chk_valid("postRstEnd", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
